// File: rtl/fifo_ctrl_8x16_pkg.sv
// Shared sizing defaults for the 8x16 FIFO controller and its companion dual-port RAM.
package fifo_ctrl_8x16_pkg;
   localparam int RAM_WIDTH_DEF = 16;
   localparam int RAM_DEPTH_DEF = 8;
   localparam int ADDR_SIZE_DEF = 3;
   localparam int AF_THR_DEF    = 6;
   localparam int AE_THR_DEF    = 2;
endpackage

// File: rtl/fifo_ctrl_8x16.sv
// Pointer/flag controller for a single-clock FIFO built on an external dual-port RAM.
// Read data appears on the RAM output one cycle after an accepted pop, flagged by dout_valid.
module fifo_ctrl_8x16
   import fifo_ctrl_8x16_pkg::*;
#(
   parameter int RAM_WIDTH = RAM_WIDTH_DEF,
   parameter int RAM_DEPTH = RAM_DEPTH_DEF,
   parameter int ADDR_SIZE = ADDR_SIZE_DEF,
   parameter int AF_THR    = AF_THR_DEF,
   parameter int AE_THR    = AE_THR_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 push,
   input  logic                 pop,
   output logic                 ram_wr_en,
   output logic [ADDR_SIZE-1:0] ram_wr_addr,
   output logic                 ram_rd_en,
   output logic [ADDR_SIZE-1:0] ram_rd_addr,
   output logic                 dout_valid,
   output logic                 full,
   output logic                 empty,
   output logic                 almost_full,
   output logic                 almost_empty,
   output logic [ADDR_SIZE:0]   count,
   output logic                 overflow,
   output logic                 underflow
);

   localparam logic [ADDR_SIZE:0] ONE    = {{ADDR_SIZE{1'b0}}, 1'b1};
   localparam logic [ADDR_SIZE:0] AF_LVL = AF_THR[ADDR_SIZE:0];
   localparam logic [ADDR_SIZE:0] AE_LVL = AE_THR[ADDR_SIZE:0];

   logic [ADDR_SIZE:0] wr_ptr, rd_ptr;
   logic               push_acc, pop_acc;

   // Extra MSB on each pointer distinguishes full (lap ahead) from empty (same lap).
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[ADDR_SIZE] != rd_ptr[ADDR_SIZE]) &&
                  (wr_ptr[ADDR_SIZE-1:0] == rd_ptr[ADDR_SIZE-1:0]);

   // Gated by rst_n so the RAM sees no stray write or read while in reset.
   assign push_acc = rst_n & push & ~full;
   assign pop_acc  = rst_n & pop & ~empty;

   assign ram_wr_en   = push_acc;
   assign ram_wr_addr = wr_ptr[ADDR_SIZE-1:0];
   assign ram_rd_addr = rd_ptr[ADDR_SIZE-1:0];
   // Hold rd_en through the valid cycle so the RAM keeps driving data_out.
   assign ram_rd_en   = pop_acc | dout_valid;

   assign almost_full  = (count >= AF_LVL);
   assign almost_empty = (count <= AE_LVL);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         dout_valid <= 1'b0;
         overflow   <= 1'b0;
         underflow  <= 1'b0;
      end else begin
         if (push_acc) wr_ptr <= wr_ptr + ONE;
         if (pop_acc)  rd_ptr <= rd_ptr + ONE;
         dout_valid <= pop_acc;
         case ({push_acc, pop_acc})
            2'b10:   count <= count + ONE;
            2'b01:   count <= count - ONE;
            default: count <= count;
         endcase
         if (push && full)  overflow  <= 1'b1;
         if (pop  && empty) underflow <= 1'b1;
      end
   end

endmodule
